uart_rx_buffered: RTL and testbench

//  Serial receive front end for the top-level rx pin: synchronises the async

---
 rtl/uart_rx_pkg.sv | 22 ++
 rtl/uart_rx_fifo.sv | 63 ++++++
 rtl/uart_rx_buffered.sv | 161 ++++++++++++++++
 tb/tb_uart_rx_buffered.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg
//   Shared definitions for the UART receive path: receiver FSM state
//   encoding, the default baud divider and the number of data bits per
//   frame. Imported by the receiver top and kept free of any logic so the
//   future transmit path can reuse it.
package uart_rx_pkg;

    // Receiver FSM states (2-bit encoding)
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

    // 50 MHz system clock / 115200 baud
    localparam int DEF_CLK_DIV = 434;

    // Data bits per 8N1 frame
    localparam int FRAME_BITS = 8;

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Small synchronous FIFO with combinational read of the head entry.
//   Pointers carry one extra bit so full and empty are distinguished by
//   the pointer difference alone.
// Ports
//   clk    in          system clock
//   rst_n  in          async active-low reset, empties the FIFO
//   push   in          write wdata this cycle
//   wdata  in  WIDTH   data to write
//   pop    in          remove head entry this cycle (ignored when empty)
//   rdata  out WIDTH   head entry, meaningful only while empty=0
//   level  out AW+1    number of entries held, 0..2**AW
//   full   out         level == 2**AW
//   empty  out         level == 0
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [AW:0]      level,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign level = wr_ptr - rd_ptr;
    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (level == '0);
    assign rdata = mem[rd_ptr[AW-1:0]];

    // A push into a full FIFO is only taken when the head is popped in the
    // same cycle; the write then lands in the slot being vacated.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset; entries are only visible once written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered
//   Serial receive front end: synchronises the asynchronous rx line,
//   deserialises 8N1 frames (LSB first) and queues received bytes in a
//   FIFO that the CPU register file pops.
// Ports
//   clk        in             system clock, rising edge
//   rst_n      in             async active-low reset
//   rx         in             serial input, async to clk, idle high
//   rd         in             pop strobe, one byte per cycle high
//   data_o     out 8          FIFO head, valid only while avail=1
//   avail      out            FIFO not empty
//   level      out FIFO_AW+1  bytes held
//   overflow   out            sticky: byte dropped because FIFO full
//   frame_err  out            sticky: stop bit sampled low
//   clr_err    in             clears overflow and frame_err
module uart_rx_buffered
    import uart_rx_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV,
    parameter int FIFO_AW = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rx,
    input  logic               rd,
    output logic [7:0]         data_o,
    output logic               avail,
    output logic [FIFO_AW:0]   level,
    output logic               overflow,
    output logic               frame_err,
    input  logic               clr_err
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLK_DIV - 1);

    logic            sync1;
    logic            rxs;
    rx_state_t       state,  state_n;
    logic [CW-1:0]   cnt,    cnt_n;
    logic [2:0]      bitcnt, bitcnt_n;
    logic [7:0]      shreg,  shreg_n;
    logic            tick;
    logic            push_byte;
    logic            ferr_set;
    logic            fifo_full;
    logic            fifo_empty;

    // Two-flop synchroniser, reset to the idle line level so a reset never
    // looks like a start edge unless the line really is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rx;
            rxs   <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            bitcnt <= '0;
            shreg  <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            bitcnt <= bitcnt_n;
            shreg  <= shreg_n;
        end
    end

    assign tick = (cnt == '0);

    // The start bit is timed to its midpoint with a half-period load, so
    // every later tick samples the middle of a bit. Leaving STOP at the
    // mid-stop sample lets a following start edge be caught immediately.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bitcnt_n  = bitcnt;
        shreg_n   = shreg;
        push_byte = 1'b0;
        ferr_set  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rxs) begin
                    state_n = ST_START;
                    cnt_n   = HALF_LOAD;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (rxs) begin
                        state_n = ST_IDLE;
                    end else begin
                        state_n  = ST_DATA;
                        cnt_n    = FULL_LOAD;
                        bitcnt_n = '0;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shreg_n  = {rxs, shreg[7:1]};
                    cnt_n    = FULL_LOAD;
                    bitcnt_n = bitcnt + 1'b1;
                    if (bitcnt == 3'(FRAME_BITS - 1)) state_n = ST_STOP;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (rxs) push_byte = 1'b1;
                    else     ferr_set  = 1'b1;
                    state_n = ST_IDLE;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Sticky error flags; a new error in the same cycle wins over a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (push_byte && fifo_full && !rd) overflow <= 1'b1;
            else if (clr_err)                  overflow <= 1'b0;
            if (ferr_set)     frame_err <= 1'b1;
            else if (clr_err) frame_err <= 1'b0;
        end
    end

    uart_rx_fifo #(
        .WIDTH (8),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_byte),
        .wdata (shreg),
        .pop   (rd),
        .rdata (data_o),
        .level (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign avail = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// tb_uart_rx_buffered
//   Directed bench for uart_rx_buffered with CLK_DIV=16 (16 clk per bit)
//   and a 4-entry FIFO.
module tb_uart_rx_buffered;

    localparam int CLK_DIV = 16;
    localparam int FIFO_AW = 2;

    logic             clk;
    logic             rst_n;
    logic             rx;
    logic             rd;
    logic [7:0]       data_o;
    logic             avail;
    logic [FIFO_AW:0] level;
    logic             overflow;
    logic             frame_err;
    logic             clr_err;

    int checks;
    int failures;

    uart_rx_buffered #(
        .CLK_DIV (CLK_DIV),
        .FIFO_AW (FIFO_AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rd        (rd),
        .data_o    (data_o),
        .avail     (avail),
        .level     (level),
        .overflow  (overflow),
        .frame_err (frame_err),
        .clr_err   (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one frame starting at the current negedge; returns on the
    // negedge that ends the stop bit with the line back high.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CLK_DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CLK_DIV) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CLK_DIV) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic pop_one();
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (avail !== 1'b0) begin failures++; $display("[TB] FAIL reset_avail got=%b exp=0", avail); end
        checks++; if (level !== 3'd0) begin failures++; $display("[TB] FAIL reset_level got=%0d exp=0", level); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_overflow got=%b exp=0", overflow); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_frame_err got=%b exp=0", frame_err); end
    endtask

    task automatic test_idle();
        repeat (2000) @(negedge clk);
        checks++; if (avail !== 1'b0) begin failures++; $display("[TB] FAIL idle_avail got=%b exp=0", avail); end
        checks++; if (level !== 3'd0) begin failures++; $display("[TB] FAIL idle_level got=%0d exp=0", level); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL idle_overflow got=%b exp=0", overflow); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("[TB] FAIL idle_frame_err got=%b exp=0", frame_err); end
    endtask

    task automatic test_back_to_back();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h3C, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (level !== 3'd2) begin failures++; $display("[TB] FAIL b2b_level got=%0d exp=2", level); end
        checks++; if (data_o !== 8'hA5) begin failures++; $display("[TB] FAIL b2b_first got=%h exp=a5", data_o); end
        pop_one();
        checks++; if (data_o !== 8'h3C) begin failures++; $display("[TB] FAIL b2b_second got=%h exp=3c", data_o); end
        checks++; if (level !== 3'd1) begin failures++; $display("[TB] FAIL b2b_level1 got=%0d exp=1", level); end
        pop_one();
        checks++; if (avail !== 1'b0) begin failures++; $display("[TB] FAIL b2b_empty got=%b exp=0", avail); end
        pop_one();
        checks++; if (level !== 3'd0) begin failures++; $display("[TB] FAIL pop_empty_level got=%0d exp=0", level); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("[TB] FAIL b2b_frame_err got=%b exp=0", frame_err); end
    endtask

    task automatic test_glitch();
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        checks++; if (level !== 3'd0) begin failures++; $display("[TB] FAIL glitch_level got=%0d exp=0", level); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("[TB] FAIL glitch_frame_err got=%b exp=0", frame_err); end
    endtask

    task automatic test_frame_error();
        logic fe_seen;
        send_byte(8'h55, 1'b0);
        repeat (20) @(negedge clk);
        checks++; if (frame_err !== 1'b1) begin failures++; $display("[TB] FAIL ferr_set got=%b exp=1", frame_err); end
        checks++; if (level !== 3'd0) begin failures++; $display("[TB] FAIL ferr_level got=%0d exp=0", level); end
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        checks++; if (frame_err !== 1'b0) begin failures++; $display("[TB] FAIL ferr_clear got=%b exp=0", frame_err); end
        // clr_err held high across the bad stop bit; the error must still stick
        fe_seen = 1'b0;
        fork
            send_byte(8'h55, 1'b0);
            begin
                clr_err = 1'b1;
                repeat (155) @(negedge clk);
                clr_err = 1'b0;
                fe_seen = frame_err;
            end
        join
        checks++; if (fe_seen !== 1'b1) begin failures++; $display("[TB] FAIL ferr_beats_clr got=%b exp=1", fe_seen); end
        repeat (20) @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    task automatic test_overflow();
        logic [7:0] exp_bytes [4];
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (level !== 3'd4) begin failures++; $display("[TB] FAIL ovf_level got=%0d exp=4", level); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_flag got=%b exp=1", overflow); end
        checks++; if (data_o !== 8'h01) begin failures++; $display("[TB] FAIL ovf_head got=%h exp=01", data_o); end
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL ovf_clear got=%b exp=0", overflow); end
        // rd is high on exactly the clock edge that pushes 0x06
        fork
            send_byte(8'h06, 1'b1);
            begin
                repeat (154) @(negedge clk);
                rd = 1'b1;
                @(negedge clk);
                rd = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        checks++; if (level !== 3'd4) begin failures++; $display("[TB] FAIL full_push_pop_level got=%0d exp=4", level); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL full_push_pop_ovf got=%b exp=0", overflow); end
        exp_bytes[0] = 8'h02;
        exp_bytes[1] = 8'h03;
        exp_bytes[2] = 8'h04;
        exp_bytes[3] = 8'h06;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (data_o !== exp_bytes[i]) begin
                failures++;
                $display("[TB] FAIL ovf_read%0d got=%h exp=%h", i, data_o, exp_bytes[i]);
            end
            pop_one();
        end
        checks++; if (avail !== 1'b0) begin failures++; $display("[TB] FAIL ovf_drained got=%b exp=0", avail); end
    endtask

    task automatic test_reset_mid_frame();
        send_byte(8'h77, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (level !== 3'd1) begin failures++; $display("[TB] FAIL pre_rst_level got=%0d exp=1", level); end
        // 0xFF frame: start bit, then reset inside data bit 4
        rx = 1'b0;
        repeat (CLK_DIV) @(negedge clk);
        rx = 1'b1;
        repeat (4 * CLK_DIV + 8) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        checks++; if (level !== 3'd0) begin failures++; $display("[TB] FAIL midrst_level got=%0d exp=0", level); end
        checks++; if (avail !== 1'b0) begin failures++; $display("[TB] FAIL midrst_avail got=%b exp=0", avail); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("[TB] FAIL midrst_frame_err got=%b exp=0", frame_err); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL midrst_overflow got=%b exp=0", overflow); end
        send_byte(8'h81, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (level !== 3'd1) begin failures++; $display("[TB] FAIL post_rst_level got=%0d exp=1", level); end
        checks++; if (data_o !== 8'h81) begin failures++; $display("[TB] FAIL post_rst_data got=%h exp=81", data_o); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("[TB] FAIL post_rst_frame_err got=%b exp=0", frame_err); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        rx       = 1'b1;
        rd       = 1'b0;
        clr_err  = 1'b0;
        @(negedge clk);
        test_reset();
        test_idle();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_overflow();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL timeout got=running exp=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
